pipe_stage_skid: RTL and testbench

PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

---
 rtl/pipe_stage_skid_if.sv | 25 ++
 rtl/pipe_stage_skid.sv | 160 ++++++++++++++++
 tb/tb_pipe_stage_skid.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_skid_if.sv
// rtl/pipe_stage_skid_if.sv - upstream/downstream handshake bundle for pipe_stage_skid
// Slave modport is the stage's view; master modport is the surrounding pipeline's view.
interface pipe_stage_skid_if #(
  parameter int PC_W    = 32,
  parameter int INSTR_W = 32
);
  logic               in_valid;
  logic               in_ready;
  logic [PC_W-1:0]    in_pc;
  logic [INSTR_W-1:0] in_instr;
  logic               out_valid;
  logic               out_ready;
  logic [PC_W-1:0]    out_pc;
  logic [INSTR_W-1:0] out_instr;

  modport slave (
    input  in_valid, in_pc, in_instr, out_ready,
    output in_ready, out_valid, out_pc, out_instr
  );

  modport master (
    output in_valid, in_pc, in_instr, out_ready,
    input  in_ready, out_valid, out_pc, out_instr
  );
endinterface

// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - registered pipeline stage with one-entry skid buffer and flush
// Optional performance counters (stall_cnt, flush_cnt) exist only when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_skid #(
  parameter int                 PC_W      = 32,
  parameter int                 INSTR_W   = 32,
  parameter logic [INSTR_W-1:0] NOP_INSTR = '0,
  parameter int                 CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  pipe_stage_skid_if.slave bus,
  output logic [1:0]       occupancy
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  // State value doubles as the occupancy count.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("pipe_stage_skid: CNT_W must be at least 1");
  end

  logic [1:0]         r_state;
  logic               r_out_valid;
  logic               r_in_ready;
  logic [PC_W-1:0]    r_main_pc;
  logic [INSTR_W-1:0] r_main_instr;
  logic [PC_W-1:0]    r_skid_pc;
  logic [INSTR_W-1:0] r_skid_instr;

  logic               w_in_xfer;
  logic               w_out_xfer;
  logic [1:0]         w_nxt_state;
  logic [PC_W-1:0]    w_nxt_main_pc;
  logic [INSTR_W-1:0] w_nxt_main_instr;
  logic [PC_W-1:0]    w_nxt_skid_pc;
  logic [INSTR_W-1:0] w_nxt_skid_instr;

  assign w_in_xfer  = bus.in_valid & r_in_ready;
  assign w_out_xfer = r_out_valid & bus.out_ready;

  always_comb begin
    w_nxt_state      = r_state;
    w_nxt_main_pc    = r_main_pc;
    w_nxt_main_instr = r_main_instr;
    w_nxt_skid_pc    = r_skid_pc;
    w_nxt_skid_instr = r_skid_instr;
    if (flush) begin
      w_nxt_state      = ST_EMPTY;
      w_nxt_main_pc    = '0;
      w_nxt_main_instr = NOP_INSTR;
      w_nxt_skid_pc    = '0;
      w_nxt_skid_instr = NOP_INSTR;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_xfer) begin
            w_nxt_state      = ST_BUSY;
            w_nxt_main_pc    = bus.in_pc;
            w_nxt_main_instr = bus.in_instr;
          end
        end
        ST_BUSY: begin
          if (w_in_xfer && w_out_xfer) begin
            w_nxt_main_pc    = bus.in_pc;
            w_nxt_main_instr = bus.in_instr;
          end else if (w_in_xfer) begin
            w_nxt_state      = ST_FULL;
            w_nxt_skid_pc    = bus.in_pc;
            w_nxt_skid_instr = bus.in_instr;
          end else if (w_out_xfer) begin
            w_nxt_state      = ST_EMPTY;
            w_nxt_main_pc    = '0;
            w_nxt_main_instr = NOP_INSTR;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only the drain path exists.
          if (w_out_xfer) begin
            w_nxt_state      = ST_BUSY;
            w_nxt_main_pc    = r_skid_pc;
            w_nxt_main_instr = r_skid_instr;
            w_nxt_skid_pc    = '0;
            w_nxt_skid_instr = NOP_INSTR;
          end
        end
        default: begin
          w_nxt_state      = ST_EMPTY;
          w_nxt_main_pc    = '0;
          w_nxt_main_instr = NOP_INSTR;
          w_nxt_skid_pc    = '0;
          w_nxt_skid_instr = NOP_INSTR;
        end
      endcase
    end
  end

  // Handshake flags are registered from the next state so no output decodes state combinationally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_EMPTY;
      r_out_valid  <= 1'b0;
      r_in_ready   <= 1'b1;
      r_main_pc    <= '0;
      r_main_instr <= NOP_INSTR;
      r_skid_pc    <= '0;
      r_skid_instr <= NOP_INSTR;
    end else begin
      r_state      <= w_nxt_state;
      r_out_valid  <= (w_nxt_state != ST_EMPTY);
      r_in_ready   <= (w_nxt_state != ST_FULL);
      r_main_pc    <= w_nxt_main_pc;
      r_main_instr <= w_nxt_main_instr;
      r_skid_pc    <= w_nxt_skid_pc;
      r_skid_instr <= w_nxt_skid_instr;
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_pc    = r_main_pc;
  assign bus.out_instr = r_main_instr;
  assign occupancy     = r_state;

`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic             w_stall_evt;
  logic             w_flush_evt;

  assign w_stall_evt = r_out_valid & ~bus.out_ready;
  assign w_flush_evt = flush & (r_state != ST_EMPTY);

  // Both counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_evt && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (w_flush_evt && (r_flush_cnt != {CNT_W{1'b1}})) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - randomized and directed bench for pipe_stage_skid against a queue model
module tb_pipe_stage_skid;
  localparam int          PC_W    = 32;
  localparam int          INSTR_W = 32;
  localparam logic [31:0] NOP     = 32'h0000_0013;
`ifdef PIPE_STAGE_PERF_EN
  localparam int CNT_W = 4;
`else
  localparam int CNT_W = 16;
`endif
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } beat_t;

  logic       clk;
  logic       rst;
  logic       flush;
  logic [1:0] occupancy;
`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
`endif

  pipe_stage_skid_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

  pipe_stage_skid #(
    .PC_W(PC_W), .INSTR_W(INSTR_W), .NOP_INSTR(NOP), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .bus(bus),
    .occupancy(occupancy)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_errors = 0;
  beat_t q[$];
  int    exp_stall = 0;
  int    exp_flush = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    check("out_valid", 64'(bus.out_valid), 64'(q.size() > 0));
    check("out_pc", 64'(bus.out_pc), (q.size() > 0) ? 64'(q[0].pc) : 64'd0);
    check("out_instr", 64'(bus.out_instr), (q.size() > 0) ? 64'(q[0].instr) : 64'(NOP));
    check("occupancy", 64'(occupancy), 64'(q.size()));
    check("in_ready", 64'(bus.in_ready), 64'(q.size() < 2));
`ifdef PIPE_STAGE_PERF_EN
    check("stall_cnt", 64'(stall_cnt), 64'(exp_stall));
    check("flush_cnt", 64'(flush_cnt), 64'(exp_flush));
`endif
  endtask

  // One cycle: check what the last edge produced, then drive and advance the model.
  task automatic step(input logic iv, input logic [31:0] pc, input logic [31:0] ins,
                      input logic ordy, input logic fl);
    int    sz;
    bit    in_x;
    bit    out_x;
    beat_t b;
    @(negedge clk);
    check_state();
    bus.in_valid  = iv;
    bus.in_pc     = pc;
    bus.in_instr  = ins;
    bus.out_ready = ordy;
    flush         = fl;
    sz    = q.size();
    in_x  = iv && (sz < 2);
    out_x = (sz > 0) && ordy;
    if (sz > 0 && !ordy && exp_stall < CNT_MAX) exp_stall++;
    if (fl && sz > 0 && exp_flush < CNT_MAX) exp_flush++;
    if (fl) begin
      q.delete();
    end else begin
      if (out_x) void'(q.pop_front());
      if (in_x) begin
        b.pc    = pc;
        b.instr = ins;
        q.push_back(b);
      end
    end
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 32'h0, 32'h0, ordy, 1'b0);
  endtask

  initial begin
    int          f_before;
    logic [31:0] pc_seq;
    rst           = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_pc     = '0;
    bus.in_instr  = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_instr", 64'(bus.out_instr), 64'(NOP));
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_occupancy", 64'(occupancy), 64'd0);
    rst = 1'b1;

    // Streaming at full rate
    for (int i = 0; i < 5; i++) begin
      step(i < 4, 32'(i * 4), 32'hA000_0000 + 32'(i), 1'b1, 1'b0);
      if (i > 0) begin
        check("stream_pc", 64'(bus.out_pc), 64'((i - 1) * 4));
        check("stream_occ", 64'(occupancy), 64'd1);
        check("stream_rdy", 64'(bus.in_ready), 64'd1);
      end
    end
    idle(1'b1);

    // Backpressure fills the skid, then drains in order
    step(1'b1, 32'h10, 32'hB000_0010, 1'b0, 1'b0);
    step(1'b1, 32'h14, 32'hB000_0014, 1'b0, 1'b0);
    idle(1'b0);
    check("bp_occ", 64'(occupancy), 64'd2);
    check("bp_rdy", 64'(bus.in_ready), 64'd0);
    check("bp_hold_pc", 64'(bus.out_pc), 64'h10);
    idle(1'b1);
    idle(1'b1);
    check("bp_second_pc", 64'(bus.out_pc), 64'h14);
    idle(1'b1);
    check("bp_drained", 64'(occupancy), 64'd0);

    // Flush while FULL with a beat offered
    step(1'b1, 32'h30, 32'hC000_0030, 1'b0, 1'b0);
    step(1'b1, 32'h34, 32'hC000_0034, 1'b0, 1'b0);
    step(1'b1, 32'h40, 32'hC000_0040, 1'b0, 1'b1);
    check("fl_pre_occ", 64'(occupancy), 64'd2);
    idle(1'b1);
    check("fl_out_valid", 64'(bus.out_valid), 64'd0);
    check("fl_out_pc", 64'(bus.out_pc), 64'd0);
    check("fl_out_instr", 64'(bus.out_instr), 64'(NOP));
    check("fl_occ", 64'(occupancy), 64'd0);
    check("fl_rdy", 64'(bus.in_ready), 64'd1);
    idle(1'b1);
    check("fl_no_0x40", 64'(bus.out_valid), 64'd0);

    // Asynchronous reset while FULL
    step(1'b1, 32'h50, 32'hD000_0050, 1'b0, 1'b0);
    step(1'b1, 32'h54, 32'hD000_0054, 1'b0, 1'b0);
    idle(1'b0);
    check("ar_pre_occ", 64'(occupancy), 64'd2);
    bus.in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("ar_out_valid", 64'(bus.out_valid), 64'd0);
    check("ar_out_pc", 64'(bus.out_pc), 64'd0);
    check("ar_out_instr", 64'(bus.out_instr), 64'(NOP));
    check("ar_occ", 64'(occupancy), 64'd0);
    check("ar_rdy", 64'(bus.in_ready), 64'd1);
    q.delete();
    exp_stall = 0;
    exp_flush = 0;
    @(negedge clk);
    rst = 1'b1;
    step(1'b1, 32'h80, 32'hE000_0080, 1'b1, 1'b0);
    idle(1'b1);
    check("ar_pc80", 64'(bus.out_pc), 64'h80);
    check("ar_pc80_valid", 64'(bus.out_valid), 64'd1);
    idle(1'b1);

`ifdef PIPE_STAGE_PERF_EN
    step(1'b1, 32'h90, 32'hF000_0090, 1'b0, 1'b0);
    repeat (20) idle(1'b0);
    check("perf_stall_sat", 64'(stall_cnt), 64'd15);
    idle(1'b1);
    idle(1'b1);
    f_before = exp_flush;
    step(1'b1, 32'hA0, 32'hF000_00A0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
    idle(1'b1);
    check("perf_flush_occ1", 64'(flush_cnt), 64'(f_before + 1));
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
    idle(1'b1);
    check("perf_flush_occ0", 64'(flush_cnt), 64'(f_before + 1));
`else
    f_before = 0;
`endif

    // Random traffic with occasional flushes
    pc_seq = 32'h1000 + 32'(f_before);
    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 99) < 70, pc_seq, $urandom(),
           $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 5);
      pc_seq = pc_seq + 32'd4;
    end
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
